syla55_32x8x12cm2: RTL and testbench

// - Synthesizable model of the 32-word x 96-bit (12 byte lanes x 8 b) single-port SRAM macro behind the

---
 rtl/sram_pkg.sv | 25 ++
 rtl/sram_delay_line.sv | 33 +++
 rtl/syla55_32x8x12cm2.sv | 111 +++++++++++
 tb/tb_syla55_32x8x12cm2.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared geometry, word type and byte-lane mask helper for the 32x96 SRAM model.
`default_nettype none

package sram_pkg;

    localparam int SRAM_BYTE_W    = 8;
    localparam int SRAM_NUM_BYTES = 12;
    localparam int SRAM_DATA_W    = SRAM_BYTE_W * SRAM_NUM_BYTES;

    typedef logic [SRAM_DATA_W-1:0]    word_t;
    typedef logic [SRAM_NUM_BYTES-1:0] web_t;

    // Expands active-low per-byte write enables into a bit mask (1 = lane written).
    function automatic word_t byte_mask(input web_t web_n);
        word_t m;
        m = '0;
        for (int b = 0; b < SRAM_NUM_BYTES; b++) begin
            m[b*SRAM_BYTE_W +: SRAM_BYTE_W] = {SRAM_BYTE_W{~web_n[b]}};
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_delay_line.sv
// sram_delay_line: reset-to-zero register chain of NUM_STAGES stages (NUM_STAGES >= 1).
`default_nettype none

module sram_delay_line #(
    parameter int NUM_STAGES = 1,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  CK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] DIN,
    output logic [DATA_WIDTH-1:0] DOUT
);

    logic [DATA_WIDTH-1:0] stage_q [NUM_STAGES];

    always_ff @(posedge CK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= DIN;
            for (int i = 1; i < NUM_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign DOUT = stage_q[NUM_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/syla55_32x8x12cm2.sv
// ============================================================================
// Module      : syla55_32x8x12cm2
// Description : 32x96 single-port SRAM model, active-low CSB/WEB,
//               registered DO, optional read latency pipeline.
// Revision    : 1.1
// ============================================================================
`default_nettype none

module syla55_32x8x12cm2
    import sram_pkg::*;
#(
    parameter int    WORDS     = 32,
    parameter int    ADDR_W    = 5,
    parameter int    BYTE_W    = SRAM_BYTE_W,
    parameter int    NUM_BYTES = SRAM_NUM_BYTES,
    parameter int    READ_LAT  = 1,
    parameter string INIT_FILE = ""
) (
    input  logic                        CK,
    input  logic                        RESET,
    input  logic                        CSB,
    input  logic [NUM_BYTES-1:0]        WEB,
    input  logic [ADDR_W-1:0]           A,
    input  logic [BYTE_W*NUM_BYTES-1:0] DI,
    input  logic                        DVSE,
    input  logic [3:0]                  DVS,
    output logic [BYTE_W*NUM_BYTES-1:0] DO
);

    localparam int                C_DATA_W  = BYTE_W * NUM_BYTES;
    localparam int                C_IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_W:0]   C_WORDS_L = (ADDR_W+1)'(WORDS);

    logic [C_DATA_W-1:0] r_mem [WORDS];
    logic [C_DATA_W-1:0] r_do;
    logic [C_DATA_W-1:0] w_do_d;

    logic                w_in_range;
    logic [C_IDX_W-1:0]  w_idx;
    logic                w_rd_cmd;
    logic                w_wr_en;
    logic [C_DATA_W-1:0] w_wmask;
    logic [C_DATA_W-1:0] w_rd_data;
    logic [C_DATA_W:0]   w_pipe_in;
    logic [C_DATA_W:0]   w_pipe_out;
    logic                w_unused;

    assign w_in_range = ({1'b0, A} < C_WORDS_L);
    assign w_idx      = A[C_IDX_W-1:0];
    assign w_rd_cmd   = !CSB && (&WEB);
    assign w_wr_en    = !CSB && !(&WEB) && w_in_range;

    generate
        if (BYTE_W == SRAM_BYTE_W && NUM_BYTES == SRAM_NUM_BYTES) begin : g_pkg_mask
            assign w_wmask = byte_mask(WEB);
        end else begin : g_lane_mask
            for (genvar b = 0; b < NUM_BYTES; b++) begin : g_lane
                assign w_wmask[b*BYTE_W +: BYTE_W] = {BYTE_W{~WEB[b]}};
            end
        end
    endgenerate

    // Array has no reset: contents survive RESET by design.
    always_ff @(posedge CK) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= (r_mem[w_idx] & ~w_wmask) | (DI & w_wmask);
        end
    end

    assign w_unused = ^{DVSE, DVS, (INIT_FILE == "")};

    // Out-of-range reads still complete, returning zero.
    assign w_rd_data = (w_rd_cmd && w_in_range) ? r_mem[w_idx] : '0;
    assign w_pipe_in = {w_rd_cmd, w_rd_data};

    generate
        if (READ_LAT <= 1) begin : g_no_delay
            assign w_pipe_out = w_pipe_in;
        end else begin : g_delay
            sram_delay_line #(
                .NUM_STAGES (READ_LAT - 1),
                .DATA_WIDTH (C_DATA_W + 1)
            ) u_delay (
                .CK    (CK),
                .RESET (RESET),
                .DIN   (w_pipe_in),
                .DOUT  (w_pipe_out)
            );
        end
    endgenerate

    always_comb begin
        w_do_d = r_do;
        if (w_pipe_out[C_DATA_W]) begin
            w_do_d = w_pipe_out[C_DATA_W-1:0];
        end
    end

    always_ff @(posedge CK or posedge RESET) begin
        if (RESET) begin
            r_do <= '0;
        end else begin
            r_do <= w_do_d;
        end
    end

    assign DO = r_do;

endmodule

`default_nettype wire

// File: tb/tb_syla55_32x8x12cm2.sv
// tb_syla55_32x8x12cm2: directed checks of the SRAM model (default build plus ADDR_W=6, READ_LAT=3).
`default_nettype none

module tb_syla55_32x8x12cm2;

    logic        ck   = 1'b0;
    logic        rst  = 1'b1;
    logic        csb  = 1'b1;
    logic [11:0] web  = '1;
    logic [4:0]  a    = '0;
    logic [95:0] di   = '0;
    logic        dvse = 1'b0;
    logic [3:0]  dvs  = '0;
    logic [95:0] dout;

    logic        csb2 = 1'b1;
    logic [11:0] web2 = '1;
    logic [5:0]  a2   = '0;
    logic [95:0] di2  = '0;
    logic [95:0] dout2;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [95:0] D3  = 96'h0123456789ABCDEF012345AB;
    localparam logic [95:0] D5  = 96'hFEDCBA9876543210DEADBEEF;
    localparam logic [95:0] X1  = {3{32'hCAFEF00D}};
    localparam logic [95:0] X2  = {3{32'h0BADC0DE}};
    localparam logic [95:0] P5A = {12{8'h5A}};
    localparam logic [95:0] V31 = {3{32'h31313131}};
    localparam logic [95:0] V8  = {3{32'h08080808}};
    localparam logic [95:0] V40 = {3{32'h40404040}};

    always #5 ck = ~ck;

    syla55_32x8x12cm2 u_dut (
        .CK    (ck),
        .RESET (rst),
        .CSB   (csb),
        .WEB   (web),
        .A     (a),
        .DI    (di),
        .DVSE  (dvse),
        .DVS   (dvs),
        .DO    (dout)
    );

    syla55_32x8x12cm2 #(
        .ADDR_W   (6),
        .READ_LAT (3)
    ) u_dut6 (
        .CK    (ck),
        .RESET (rst),
        .CSB   (csb2),
        .WEB   (web2),
        .A     (a2),
        .DI    (di2),
        .DVSE  (1'b0),
        .DVS   (4'h0),
        .DO    (dout2)
    );

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic wr(input logic [4:0] ad, input logic [95:0] d, input logic [11:0] we);
        csb = 1'b0; a = ad; di = d; web = we;
        tick();
        csb = 1'b1; web = '1;
    endtask

    task automatic rd(input logic [4:0] ad);
        csb = 1'b0; a = ad; web = '1;
        tick();
        csb = 1'b1;
    endtask

    task automatic wr2(input logic [5:0] ad, input logic [95:0] d);
        csb2 = 1'b0; a2 = ad; di2 = d; web2 = '0;
        tick();
        csb2 = 1'b1; web2 = '1;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (dout !== 96'h0) begin n_fail++; $display("FAIL reset_do: got %h want 0", dout); end
        n_tests++;
        if (dout2 !== 96'h0) begin n_fail++; $display("FAIL reset_do_lat3: got %h want 0", dout2); end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        wr(5'd3, D3, 12'h000);
        rd(5'd3);
        n_tests++;
        if (dout !== D3) begin n_fail++; $display("FAIL wr_rd_a3: got %h want %h", dout, D3); end
        wr(5'd5, D5, 12'h000);
        n_tests++;
        if (dout !== D3) begin n_fail++; $display("FAIL write_holds_do: got %h want %h", dout, D3); end
        tick();
        tick();
        n_tests++;
        if (dout !== D3) begin n_fail++; $display("FAIL idle_hold: got %h want %h", dout, D3); end
        rd(5'd5);
        n_tests++;
        if (dout !== D5) begin n_fail++; $display("FAIL wr_rd_a5: got %h want %h", dout, D5); end
    endtask

    task automatic test_byte_mask();
        logic [95:0] exp;
        wr(5'd7, {12{8'hFF}}, 12'h000);
        wr(5'd7, 96'h0, 12'hFFE);
        rd(5'd7);
        exp = {{11{8'hFF}}, 8'h00};
        n_tests++;
        if (dout !== exp) begin n_fail++; $display("FAIL mask_lane0: got %h want %h", dout, exp); end
        wr(5'd7, {8'hAB, 88'h0}, 12'h7FF);
        rd(5'd7);
        exp = {8'hAB, {10{8'hFF}}, 8'h00};
        n_tests++;
        if (dout !== exp) begin n_fail++; $display("FAIL mask_lane11: got %h want %h", dout, exp); end
    endtask

    task automatic test_back_to_back();
        logic [95:0] exp [3];
        exp[0] = {12{8'h10}};
        exp[1] = {12{8'h21}};
        exp[2] = {12{8'h32}};
        for (int i = 0; i < 3; i++) wr(5'(i), exp[i], 12'h000);
        csb = 1'b0; web = '1;
        for (int i = 0; i < 3; i++) begin
            a = 5'(i);
            tick();
            n_tests++;
            if (dout !== exp[i]) begin n_fail++; $display("FAIL b2b_rd%0d: got %h want %h", i, dout, exp[i]); end
        end
        csb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (dout !== exp[2]) begin n_fail++; $display("FAIL b2b_hold%0d: got %h want %h", i, dout, exp[2]); end
        end
    endtask

    task automatic test_read_then_write();
        wr(5'd4, X1, 12'h000);
        csb = 1'b0; a = 5'd4; web = '1;
        tick();
        n_tests++;
        if (dout !== X1) begin n_fail++; $display("FAIL rw_read_old: got %h want %h", dout, X1); end
        web = '0; di = X2;
        tick();
        n_tests++;
        if (dout !== X1) begin n_fail++; $display("FAIL rw_captured_kept: got %h want %h", dout, X1); end
        web = '1;
        tick();
        csb = 1'b1;
        n_tests++;
        if (dout !== X2) begin n_fail++; $display("FAIL rw_read_new: got %h want %h", dout, X2); end
    endtask

    task automatic test_reset_async();
        wr(5'd9, P5A, 12'h000);
        rd(5'd9);
        n_tests++;
        if (dout !== P5A) begin n_fail++; $display("FAIL pre_reset_do: got %h want %h", dout, P5A); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (dout !== 96'h0) begin n_fail++; $display("FAIL async_reset_do: got %h want 0", dout); end
        #2 rst = 1'b0;
        tick();
        n_tests++;
        if (dout !== 96'h0) begin n_fail++; $display("FAIL post_reset_hold: got %h want 0", dout); end
        rd(5'd9);
        n_tests++;
        if (dout !== P5A) begin n_fail++; $display("FAIL mem_preserved: got %h want %h", dout, P5A); end
    endtask

    task automatic test_dvs_x();
        dvse = 1'bx; dvs = 4'bxxxx;
        rd(5'd3);
        n_tests++;
        if (dout !== D3) begin n_fail++; $display("FAIL dvs_x_rd3: got %h want %h", dout, D3); end
        wr(5'd6, D5, 12'h000);
        rd(5'd5);
        n_tests++;
        if (dout !== D5) begin n_fail++; $display("FAIL dvs_x_rd5: got %h want %h", dout, D5); end
        dvse = 1'b0; dvs = 4'h0;
    endtask

    task automatic test_out_of_range();
        logic [95:0] exp [6];
        exp[0] = 96'h0; exp[1] = 96'h0; exp[2] = V31;
        exp[3] = 96'h0; exp[4] = V8;    exp[5] = V8;
        wr2(6'd31, V31);
        wr2(6'd8, V8);
        wr2(6'd40, V40);
        for (int i = 0; i < 6; i++) begin
            csb2 = (i < 3) ? 1'b0 : 1'b1;
            web2 = '1;
            a2   = (i == 0) ? 6'd31 : (i == 1) ? 6'd40 : 6'd8;
            tick();
            n_tests++;
            if (dout2 !== exp[i]) begin n_fail++; $display("FAIL lat3_oor_e%0d: got %h want %h", i, dout2, exp[i]); end
        end
        csb2 = 1'b1;
    endtask

    task automatic test_reset_midread();
        csb2 = 1'b0; a2 = 6'd31; web2 = '1;
        tick();
        csb2 = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (dout2 !== 96'h0) begin n_fail++; $display("FAIL lat3_async_reset: got %h want 0", dout2); end
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (dout2 !== 96'h0) begin n_fail++; $display("FAIL lat3_dropped_e%0d: got %h want 0", i, dout2); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_back_to_back();
        test_read_then_write();
        test_reset_async();
        test_dvs_x();
        test_out_of_range();
        test_reset_midread();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule

`default_nettype wire
